// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin, burst-aware arbiter sharing the single write port of the
//   asynchronous FIFO between NUM_REQ write-domain requesters. A granted
//   requester keeps ownership for up to MAX_BURST consecutive writes.
//
// Ports
//   W_CLK     write-domain clock
//   W_RST     asynchronous, active-low reset
//   req       per-requester level request, held until granted
//   req_data  packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full      FIFO full flag (write domain)
//   gnt       one-hot grant; the word is accepted in the same cycle
//   W_inc     FIFO write enable (|gnt)
//   WR_DATA   data of the granted requester, 0 when nothing is granted
//   owner_id  registered current/last owner index
//   busy      registered, 1 while a burst is owned
//
// Optional build macro FIFO_WR_ARB_STALL_CNT_EN adds:
//   stall_clr  synchronous clear of stall_cnt (wins over increment)
//   stall_cnt  saturating count of cycles with full=1 and any request
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          W_CLK,
  input  logic                          W_RST,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          W_inc,
  output logic [DATA_WIDTH-1:0]         WR_DATA,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic                          busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  input  logic                          stall_clr,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   owner_n;
  logic [IDX_W-1:0]   rr_ptr, rr_n;
  logic [CNT_W-1:0]   burst_cnt, cnt_n;
  logic [CNT_W-1:0]   cnt_p1;

  logic               found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand_idx;
  int unsigned        cand;

  logic               grant_en;
  logic [IDX_W-1:0]   grant_idx;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  assign cnt_p1 = burst_cnt + 1'b1;

  // State register
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      state     <= IDLE;
      owner_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      owner_id  <= owner_n;
      rr_ptr    <= rr_n;
      burst_cnt <= cnt_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    owner_n = owner_id;
    rr_n    = rr_ptr;
    cnt_n   = burst_cnt;
    case (state)
      IDLE: begin
        if (!full && found) begin
          owner_n = sel_idx;
          if (MAX_BURST == 1) begin
            rr_n = wrap_inc(sel_idx);
          end else begin
            state_n = OWN;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      OWN: begin
        // A dropped owner request releases even under full; the release
        // cycle grants nobody, so other requesters wait one bubble.
        if (!req[owner_id]) begin
          state_n = IDLE;
          cnt_n   = '0;
          rr_n    = wrap_inc(owner_id);
        end else if (!full) begin
          if (cnt_p1 == CNT_W'(MAX_BURST)) begin
            state_n = IDLE;
            cnt_n   = '0;
            rr_n    = wrap_inc(owner_id);
          end else begin
            cnt_n = cnt_p1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output logic; grant is suppressed while reset is asserted.
  always_comb begin
    grant_en  = 1'b0;
    grant_idx = sel_idx;
    if (W_RST && !full) begin
      case (state)
        IDLE: grant_en = found;
        OWN: begin
          grant_en  = req[owner_id];
          grant_idx = owner_id;
        end
        default: grant_en = 1'b0;
      endcase
    end
  end

  assign gnt     = grant_en ? (NUM_REQ'(1) << grant_idx) : '0;
  assign W_inc   = grant_en;
  assign WR_DATA = grant_en ? req_data[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH] : '0;
  assign busy    = (state == OWN);

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (full && (|req) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a 4-requester/burst-4 instance
// and a 3-requester/burst-1 instance sharing clock and reset.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] dval  [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic [7:0] dval3 [3] = '{8'h15, 8'h26, 8'h37};

  // 4 requesters, MAX_BURST=4
  logic [3:0]  req = '0;
  logic [31:0] req_data;
  logic        full = 1'b0;
  logic [3:0]  gnt;
  logic        winc;
  logic [7:0]  wr_data;
  logic [1:0]  owner_id;
  logic        busy;

  // 3 requesters, MAX_BURST=1
  logic [2:0]  req3 = '0;
  logic [23:0] req_data3;
  logic        full3 = 1'b0;
  logic [2:0]  gnt3;
  logic        winc3;
  logic [7:0]  wr_data3;
  logic [1:0]  owner_id3;
  logic        busy3;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic        stall_clr = 1'b0;
  logic [15:0] stall_cnt;
  logic        stall_clr3 = 1'b0;
  logic [15:0] stall_cnt3;
`endif

  assign req_data  = {dval[3], dval[2], dval[1], dval[0]};
  assign req_data3 = {dval3[2], dval3[1], dval3[0]};

  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .W_CLK(clk), .W_RST(rst_n), .req(req), .req_data(req_data), .full(full),
    .gnt(gnt), .W_inc(winc), .WR_DATA(wr_data), .owner_id(owner_id), .busy(busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
  );

  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3), .MAX_BURST(1)) dut3 (
    .W_CLK(clk), .W_RST(rst_n), .req(req3), .req_data(req_data3), .full(full3),
    .gnt(gnt3), .W_inc(winc3), .WR_DATA(wr_data3), .owner_id(owner_id3), .busy(busy3)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    , .stall_clr(stall_clr3), .stall_cnt(stall_cnt3)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    int unsigned sel;
    int unsigned gnt;
    int unsigned data;
    int unsigned winc;
    int unsigned owner;
    int unsigned busy;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned data_of(input int unsigned sel, input logic [3:0] g);
    int unsigned d = 0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) d = (sel == 0) ? 32'(dval[i]) : ((i < 3) ? 32'(dval3[i]) : 0);
    end
    return d;
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    req   = '0;
    full  = 1'b0;
    req3  = '0;
    full3 = 1'b0;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    stall_clr  = 1'b0;
    stall_clr3 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drive one cycle of stimulus (called just after a rising edge), queue the
  // expected outputs, then pop and compare at the falling edge.
  task automatic step(input int unsigned sel, input logic [3:0] r, input logic f,
                      input logic [3:0] eg, input logic [1:0] eo, input logic eb);
    exp_t e;
    exp_t got;
    if (sel == 0) begin
      req  = r;
      full = f;
    end else begin
      req3  = r[2:0];
      full3 = f;
    end
    e.sel   = sel;
    e.gnt   = 32'(eg);
    e.data  = data_of(sel, eg);
    e.winc  = (eg != 4'b0000) ? 1 : 0;
    e.owner = 32'(eo);
    e.busy  = 32'(eb);
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    if (got.sel == 0) begin
      check("gnt", 32'(gnt), got.gnt);
      check("WR_DATA", 32'(wr_data), got.data);
      check("W_inc", 32'(winc), got.winc);
      check("owner_id", 32'(owner_id), got.owner);
      check("busy", 32'(busy), got.busy);
    end else begin
      check("gnt3", 32'(gnt3), got.gnt);
      check("WR_DATA3", 32'(wr_data3), got.data);
      check("W_inc3", 32'(winc3), got.winc);
      check("owner_id3", 32'(owner_id3), got.owner);
      check("busy3", 32'(busy3), got.busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;

    // Fairness: all requesting, bursts of 4 rotate 0,1,2,3,0 back to back.
    for (int k = 0; k < 20; k++) begin
      int g;
      g = (k / 4) % 4;
      v.rst   = (k == 0);
      v.req   = 4'b1111;
      v.full  = 1'b0;
      v.gnt   = 4'(1 << g);
      v.owner = (k % 4 != 0) ? 2'(g) : ((k == 0) ? 2'd0 : 2'((g + 3) % 4));
      v.busy  = (k % 4 != 0);
      vecs.push_back(v);
    end
    // Early release: two writes from 2, bubble, then 3 wins from rr_ptr=3.
    vecs.push_back('{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b1});
    vecs.push_back('{1'b0, 4'b1001, 1'b0, 4'b1000, 2'd2, 1'b0});
    vecs.push_back('{1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1});
    // Full in IDLE blocks the grant, then the same request proceeds.
    vecs.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0});

    foreach (vecs[i]) begin
      if (vecs[i].rst) reset_dut();
      step(0, vecs[i].req, vecs[i].full, vecs[i].gnt, vecs[i].owner, vecs[i].busy);
    end

    // Full held for 5 cycles with owner 1 at burst_cnt=2.
    reset_dut();
    step(0, 4'b0010, 1'b0, 4'b0010, 2'd0, 1'b0);
    step(0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
    for (int i = 0; i < 5; i++) step(0, 4'b0110, 1'b1, 4'b0000, 2'd1, 1'b1);
    step(0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1);
    step(0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1);
    step(0, 4'b0110, 1'b0, 4'b0100, 2'd1, 1'b0);

    // Reset mid-burst: owner 3 at burst_cnt=3.
    reset_dut();
    step(0, 4'b1000, 1'b0, 4'b1000, 2'd0, 1'b0);
    step(0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1);
    step(0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1);
    rst_n = 1'b0;
    #2;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_W_inc", 32'(winc), 0);
    check("rst_WR_DATA", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner_id", 32'(owner_id), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 4'b1010, 1'b0, 4'b0010, 2'd0, 1'b0);
    step(0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1);

    // NUM_REQ=3, MAX_BURST=1: single-write rotation with 2->0 wrap.
    reset_dut();
    step(1, 4'b0111, 1'b0, 4'b0001, 2'd0, 1'b0);
    step(1, 4'b0111, 1'b0, 4'b0010, 2'd0, 1'b0);
    step(1, 4'b0111, 1'b0, 4'b0100, 2'd1, 1'b0);
    step(1, 4'b0111, 1'b0, 4'b0001, 2'd2, 1'b0);
    step(1, 4'b0111, 1'b0, 4'b0010, 2'd0, 1'b0);
    step(1, 4'b0111, 1'b0, 4'b0100, 2'd1, 1'b0);

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    reset_dut();
    for (int i = 0; i < 10; i++) step(0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0);
    check("stall_cnt_10", 32'(stall_cnt), 10);
    stall_clr = 1'b1;
    @(posedge clk);
    #1 stall_clr = 1'b0;
    check("stall_cnt_clr", 32'(stall_cnt), 0);
    repeat (65534) @(posedge clk);
    #1;
    check("stall_cnt_fffe", 32'(stall_cnt), 32'h0000FFFE);
    repeat (3) @(posedge clk);
    #1;
    check("stall_cnt_sat", 32'(stall_cnt), 32'h0000FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin, burst-aware arbiter that shares the single write port of the asynchronous FIFO between NUM_REQ write-domain requesters. It sits in the W_CLK domain between the requesters and the FIFO write controller. It drives W_inc and WR_DATA and obeys the FIFO's full flag. A granted requester keeps ownership for up to MAX_BURST consecutive writes so packet fragments stay contiguous in the FIFO.

Parameters:
DATA_WIDTH, 8, width of each requester's data word and of WR_DATA
NUM_REQ, 4, number of requesters, 2..8
MAX_BURST, 4, maximum consecutive writes per ownership, >=1

Ports:
W_CLK  input  1  write-domain clock
W_RST  input  1  reset, asynchronous, active-low
req  input  NUM_REQ  per-requester write request, level, held until granted
req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
full  input  1  FIFO full flag (write domain)
gnt  output  NUM_REQ  one-hot grant; word accepted in the same cycle gnt[i]=1
W_inc  output  1  FIFO write enable, equals |gnt
WR_DATA  output  DATA_WIDTH  req_data slice of granted requester; 0 when no grant
owner_id  output  $clog2(NUM_REQ)  registered current/last owner index
busy  output  1  registered; 1 in state OWN

Behaviour:
- Registered state: fsm {IDLE, OWN}; owner_id; rr_ptr (index holding next priority); burst_cnt (width $clog2(MAX_BURST+1)).
- Reset (W_RST low, async): fsm=IDLE, owner_id=0, rr_ptr=0, burst_cnt=0, busy=0. gnt, W_inc and WR_DATA are forced to 0 while W_RST is low.
- gnt, W_inc and WR_DATA are combinational from state, req and full. No combinational loop: full depends only on FIFO registers.
- full=1 in any state: gnt=0, W_inc=0, all registers hold, burst_cnt frozen.
- IDLE, full=0, req!=0:
  - Grant the first set req bit searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Write occurs in this cycle; owner_id<=idx.
  - If MAX_BURST==1: stay IDLE, rr_ptr<=(idx+1) mod NUM_REQ.
  - Otherwise: fsm<=OWN, burst_cnt<=1.
- IDLE, req==0: nothing changes.
- OWN, req[owner_id]=1, full=0:
  - gnt[owner_id]=1, burst_cnt<=burst_cnt+1.
  - If burst_cnt+1==MAX_BURST: fsm<=IDLE, burst_cnt<=0, rr_ptr<=(owner_id+1) mod NUM_REQ.
- OWN, req[owner_id]=0 (regardless of full):
  - No grant this cycle; other requesters are ignored (one-cycle release bubble).
  - fsm<=IDLE, burst_cnt<=0, rr_ptr<=(owner_id+1) mod NUM_REQ.
- OWN never grants a non-owner.
- Wrap: rr_ptr and the search index wrap modulo NUM_REQ; a non-power-of-2 NUM_REQ must wrap correctly (e.g. 2->0 for NUM_REQ=3).
- Reset asserted mid-burst aborts ownership immediately. No partial state survives, and the first post-reset grant starts at requester 0.
- Fairness: with all requesters continuously requesting and no full, each requester receives exactly MAX_BURST writes per round.

Optional Feature:
FIFO_WR_ARB_STALL_CNT_EN:
- Defined: adds output stall_cnt [15:0] and input stall_clr (1 bit).
- stall_cnt increments each W_CLK cycle with full=1 and (req!=0); it saturates at 16'hFFFF.
- stall_clr=1 clears it to 0 next cycle; clear takes priority over increment.
- Reset value is 0.
- Undefined: neither port exists and there is no extra logic. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset, then req=4'b1111, full=0, MAX_BURST=4 -> grants 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; W_inc=1 every cycle; WR_DATA matches the owner's slice.
- req=4'b0100 only for 2 cycles, then dropped -> 2 writes from requester 2, one bubble cycle, fsm IDLE, rr_ptr=3; next req=4'b1001 grants requester 3.
- Owner 1 at burst_cnt=2, full asserted 5 cycles -> gnt=0 and W_inc=0 for 5 cycles, owner_id=1, burst_cnt=2 held; after full drops, 2 more writes to requester 1, then requester 2.
- W_RST pulsed low while owner=3 at burst_cnt=3 -> gnt=0, busy=0, owner_id=0 during reset; after release with req=4'b1010, first grant goes to requester 1.
- NUM_REQ=3, MAX_BURST=1, req=3'b111 -> grants 0,1,2,0,1,2; busy stays 0.
- FIFO_WR_ARB_STALL_CNT_EN defined: full=1, req!=0 for 10 cycles -> stall_cnt=10; stall_clr pulse -> 0; preload 16'hFFFE with 3 further stall cycles -> stays 16'hFFFF.
